i2c_target: RTL and testbench

- I2C target (responder) for the far end of the bus driven by the team's I2C master and its clock divider.
- Oversamples SCL/SDA on the system clock, filters glitches, and detects START, repeated START and STOP.
- Matches a 7-bit address and receives write bytes into a one-byte pulse interface.
- Serves read bytes from a request/data interface, driving SDA open-drain.

---
 rtl/i2c_target.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target: filtered SCL/SDA, START/STOP detect, 7-bit address match, byte write/read.
// Latency: pin to filtered level 2+FILT clks; FSM acts one clk after the filtered edge strobe.
// Backpressure: none; every write byte is ACKed; read data must be valid on tx_data by the next SCL fall after tx_req.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILT        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    localparam logic [3:0] FILT_C = 4'(FILT);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // channel 0 = SCL, channel 1 = SDA
    logic [1:0] sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [3:0] cnt_q [2];

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       rw_q;
    logic       rd_ack_ok_q;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, tx_req_q, start_det_q, stop_det_q, busy_q;

    logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    // Synchronize both pins and only move the filtered level after FILT consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
        end else begin
            sync1_q     <= {sda_in, scl_in};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == FILT_C - 4'd1) begin
                        filt_q[i] <= sync2_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Edge strobes and bus conditions; SCL must have been high on both sides of the SDA edge
    always_comb begin
        scl_f      = filt_q[0];
        sda_f      = filt_q[1];
        scl_rise   = filt_q[0] & ~filt_prev_q[0];
        scl_fall   = ~filt_q[0] & filt_prev_q[0];
        sda_rise   = filt_q[1] & ~filt_prev_q[1];
        sda_fall   = ~filt_q[1] & filt_prev_q[1];
        start_cond = sda_fall & scl_f & filt_prev_q[0];
        stop_cond  = sda_rise & scl_f & filt_prev_q[0];
    end

    // Protocol FSM; START/STOP take priority over every state, sda_oe only moves after an SCL fall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            rd_ack_ok_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            if (start_cond) begin
                state_q     <= ADDR;
                bit_cnt_q   <= '0;
                sda_oe_q    <= 1'b0;
                start_det_q <= 1'b1;
                busy_q      <= 1'b1;
            end else if (stop_cond) begin
                state_q    <= IDLE;
                sda_oe_q   <= 1'b0;
                stop_det_q <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                // shift_q[6:0] holds the 7 address bits, sda_f is R/W
                                rw_q    <= sda_f;
                                state_q <= (shift_q[6:0] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && sda_oe_q && rw_q) tx_req_q <= 1'b1;
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (rw_q) begin
                                shift_q   <= tx_data;
                                sda_oe_q  <= ~tx_data[7];
                                bit_cnt_q <= '0;
                                state_q   <= RD_DATA;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= {shift_q[6:0], sda_f};
                                rx_valid_q <= 1'b1;
                                state_q    <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_q    <= 1'b0;
                                bit_cnt_q   <= '0;
                                rd_ack_ok_q <= 1'b0;
                                state_q     <= RD_ACK;
                            end else begin
                                sda_oe_q  <= ~shift_q[6];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                tx_req_q    <= 1'b1;
                                rd_ack_ok_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end else if (scl_fall && rd_ack_ok_q) begin
                            shift_q   <= tx_data;
                            sda_oe_q  <= ~tx_data[7];
                            bit_cnt_q <= '0;
                            state_q   <= RD_DATA;
                        end
                    end
                    WAIT_STOP: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a behavioural I2C master at SCL = clk/40 on an open-drain SDA line.
// Pulse outputs are counted by a monitor; each test task compares counter deltas and captured bytes.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, start_det, stop_det, busy;
    logic [7:0] rx_data;
    wire        sda_line = sda_m & ~sda_oe;

    int vectors = 0;
    int errors  = 0;

    int         rxv_cnt = 0, txr_cnt = 0, sd_cnt = 0, pd_cnt = 0, oe_cnt = 0, tx_idx = 0;
    logic [7:0] rx_log [8];
    logic [7:0] tx_q   [4];

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h50), .FILT(3)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_req(tx_req), .tx_data(tx_data),
        .start_det(start_det), .stop_det(stop_det), .busy(busy)
    );

    // Pulse monitor; also supplies the next read byte whenever tx_req pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (rxv_cnt < 8) rx_log[rxv_cnt] = rx_data;
                rxv_cnt++;
            end
            if (tx_req) begin
                tx_data = tx_q[tx_idx % 4];
                tx_idx++;
                txr_cnt++;
            end
            if (start_det) sd_cnt++;
            if (stop_det) pd_cnt++;
            if (sda_oe) oe_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch, output logic r);
        sda_m = b;
        tick(10);
        scl_m = 1'b1;
        if (glitch) begin
            tick(4); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(4);
        end else begin
            tick(10);
        end
        r = sda_line;
        tick(10);
        scl_m = 1'b0;
        tick(10);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(20);
        sda_m = 1'b0; tick(20);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(10);
        scl_m = 1'b1; tick(20);
        sda_m = 1'b1; tick(20);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_line);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, r);
        send_bit(1'b1, 1'b0, ack_line);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b0, r);
            d = {d[6:0], r};
        end
        send_bit(nack, 1'b0, r);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        vectors++; if (sda_oe !== 1'b0)     $display("FAIL reset_sda_oe: got %b want 0", sda_oe);
        if (sda_oe !== 1'b0) errors++;
        vectors++; if (rx_data !== 8'h00)   begin $display("FAIL reset_rx_data: got %h want 00", rx_data); errors++; end
        vectors++; if (rx_valid !== 1'b0)   begin $display("FAIL reset_rx_valid: got %b want 0", rx_valid); errors++; end
        vectors++; if (tx_req !== 1'b0)     begin $display("FAIL reset_tx_req: got %b want 0", tx_req); errors++; end
        vectors++; if (start_det !== 1'b0)  begin $display("FAIL reset_start_det: got %b want 0", start_det); errors++; end
        vectors++; if (stop_det !== 1'b0)   begin $display("FAIL reset_stop_det: got %b want 0", stop_det); errors++; end
        vectors++; if (busy !== 1'b0)       begin $display("FAIL reset_busy: got %b want 0", busy); errors++; end
        rst = 1'b0;
        tick(20);
    endtask

    task automatic test_write_match();
        int s0, p0, r0;
        logic a0, a1, a2;
        s0 = sd_cnt; p0 = pd_cnt; r0 = rxv_cnt;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h3C, a1);
        send_byte(8'hC3, a2);
        vectors++; if (busy !== 1'b1) begin $display("FAIL wr_busy_mid: got %b want 1", busy); errors++; end
        bus_stop();
        tick(10);
        vectors++; if (a0 !== 1'b0) begin $display("FAIL wr_ack_addr: got %b want 0", a0); errors++; end
        vectors++; if (a1 !== 1'b0) begin $display("FAIL wr_ack_b1: got %b want 0", a1); errors++; end
        vectors++; if (a2 !== 1'b0) begin $display("FAIL wr_ack_b2: got %b want 0", a2); errors++; end
        vectors++; if (rxv_cnt - r0 != 2) begin $display("FAIL wr_rx_count: got %0d want 2", rxv_cnt - r0); errors++; end
        vectors++; if (rx_log[r0] !== 8'h3C) begin $display("FAIL wr_rx_b1: got %h want 3c", rx_log[r0]); errors++; end
        vectors++; if (rx_log[r0+1] !== 8'hC3) begin $display("FAIL wr_rx_b2: got %h want c3", rx_log[r0+1]); errors++; end
        vectors++; if (sd_cnt - s0 != 1) begin $display("FAIL wr_start_count: got %0d want 1", sd_cnt - s0); errors++; end
        vectors++; if (pd_cnt - p0 != 1) begin $display("FAIL wr_stop_count: got %0d want 1", pd_cnt - p0); errors++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL wr_busy_end: got %b want 0", busy); errors++; end
        tick(20);
    endtask

    task automatic test_addr_mismatch();
        int p0, r0, o0;
        logic a0, a1;
        p0 = pd_cnt; r0 = rxv_cnt; o0 = oe_cnt;
        bus_start();
        send_byte(8'hA2, a0);
        send_byte(8'h55, a1);
        vectors++; if (busy !== 1'b1) begin $display("FAIL mm_busy_mid: got %b want 1", busy); errors++; end
        vectors++; if (pd_cnt - p0 != 0) begin $display("FAIL mm_stop_early: got %0d want 0", pd_cnt - p0); errors++; end
        bus_stop();
        tick(10);
        vectors++; if (a0 !== 1'b1) begin $display("FAIL mm_nack_addr: got %b want 1", a0); errors++; end
        vectors++; if (oe_cnt - o0 != 0) begin $display("FAIL mm_sda_oe_cycles: got %0d want 0", oe_cnt - o0); errors++; end
        vectors++; if (rxv_cnt - r0 != 0) begin $display("FAIL mm_rx_count: got %0d want 0", rxv_cnt - r0); errors++; end
        vectors++; if (pd_cnt - p0 != 1) begin $display("FAIL mm_stop_count: got %0d want 1", pd_cnt - p0); errors++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL mm_busy_end: got %b want 0", busy); errors++; end
        tick(20);
    endtask

    task automatic test_read();
        int t0;
        logic a0;
        logic [7:0] d1, d2;
        tx_q[tx_idx % 4]       = 8'h96;
        tx_q[(tx_idx + 1) % 4] = 8'h5A;
        t0 = txr_cnt;
        bus_start();
        send_byte(8'hA1, a0);
        recv_byte(1'b0, d1);
        recv_byte(1'b1, d2);
        vectors++; if (sda_oe !== 1'b0) begin $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); errors++; end
        bus_stop();
        tick(10);
        vectors++; if (a0 !== 1'b0) begin $display("FAIL rd_ack_addr: got %b want 0", a0); errors++; end
        vectors++; if (d1 !== 8'h96) begin $display("FAIL rd_byte1: got %h want 96", d1); errors++; end
        vectors++; if (d2 !== 8'h5A) begin $display("FAIL rd_byte2: got %h want 5a", d2); errors++; end
        vectors++; if (txr_cnt - t0 != 2) begin $display("FAIL rd_tx_req_count: got %0d want 2", txr_cnt - t0); errors++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL rd_busy_end: got %b want 0", busy); errors++; end
        tick(20);
    endtask

    task automatic test_repeated_start();
        int s0, r0, t0, p0;
        logic a0, a1, a2, r;
        logic [7:0] d;
        tx_q[tx_idx % 4] = 8'hE7;
        s0 = sd_cnt; r0 = rxv_cnt; t0 = txr_cnt; p0 = pd_cnt;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h11, a1);
        send_bit(1'b1, 1'b0, r);
        send_bit(1'b0, 1'b0, r);
        send_bit(1'b1, 1'b0, r);
        send_bit(1'b1, 1'b0, r);
        bus_start();
        send_byte(8'hA1, a2);
        recv_byte(1'b1, d);
        bus_stop();
        tick(10);
        vectors++; if ({a0, a1, a2} !== 3'b000) begin $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); errors++; end
        vectors++; if (rxv_cnt - r0 != 1) begin $display("FAIL rs_rx_count: got %0d want 1", rxv_cnt - r0); errors++; end
        vectors++; if (rx_log[r0] !== 8'h11) begin $display("FAIL rs_rx_byte: got %h want 11", rx_log[r0]); errors++; end
        vectors++; if (sd_cnt - s0 != 2) begin $display("FAIL rs_start_count: got %0d want 2", sd_cnt - s0); errors++; end
        vectors++; if (txr_cnt - t0 != 1) begin $display("FAIL rs_tx_req_count: got %0d want 1", txr_cnt - t0); errors++; end
        vectors++; if (d !== 8'hE7) begin $display("FAIL rs_read_byte: got %h want e7", d); errors++; end
        vectors++; if (pd_cnt - p0 != 1) begin $display("FAIL rs_stop_count: got %0d want 1", pd_cnt - p0); errors++; end
        tick(20);
    endtask

    task automatic test_glitch_reset();
        int r0;
        logic a0, a1, r;
        logic [7:0] b;
        r0 = rxv_cnt;
        b = 8'h5A;
        bus_start();
        send_byte(8'hA0, a0);
        for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 4), r);
        send_bit(1'b1, 1'b0, a1);
        vectors++; if (a1 !== 1'b0) begin $display("FAIL gl_ack: got %b want 0", a1); errors++; end
        vectors++; if (rxv_cnt - r0 != 1) begin $display("FAIL gl_rx_count: got %0d want 1", rxv_cnt - r0); errors++; end
        vectors++; if (rx_log[r0] !== 8'h5A) begin $display("FAIL gl_rx_byte: got %h want 5a", rx_log[r0]); errors++; end
        // 8 data bits of 0x77; target then pulls SDA for the ACK slot
        b = 8'h77;
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, r);
        vectors++; if (sda_oe !== 1'b1) begin $display("FAIL wrack_sda_oe: got %b want 1", sda_oe); errors++; end
        vectors++; if (rx_log[r0+1] !== 8'h77) begin $display("FAIL wrack_rx_byte: got %h want 77", rx_log[r0+1]); errors++; end
        rst = 1'b1;
        tick(1);
        vectors++; if (sda_oe !== 1'b0) begin $display("FAIL rst_sda_oe: got %b want 0", sda_oe); errors++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); errors++; end
        rst = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(30);
        vectors++; if (busy !== 1'b0) begin $display("FAIL rst_idle_busy: got %b want 0", busy); errors++; end
    endtask

    initial begin
        test_reset();
        test_write_match();
        test_addr_mismatch();
        test_read();
        test_repeated_start();
        test_glitch_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
